// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        SEL_IMMED = 2'd0,
        SEL_STACK = 2'd1,
        SEL_INTR  = 2'd2,
        SEL_RSVD  = 2'd3
    } pc_sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } skid_state_t;

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry skid buffer for the fetch output stage
module fetch_skid
    import fetch_pkg::*;
#(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    skid_state_t  state_q;
    logic [W-1:0] data_q;

    // push beats pop so a simultaneous refill keeps the entry FULL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else if (clear) begin
            state_q <= EMPTY;
        end else if (push) begin
            state_q <= FULL;
            data_q  <= din;
        end else if (pop) begin
            state_q <= EMPTY;
        end
    end

    assign dout = data_q;
    assign full = (state_q == FULL);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, instruction memory issue and registered IR delivery
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter int                IR_W      = 18,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] INTR_VEC  = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_ld,
    input  logic [1:0]        pc_mux_sel,
    input  logic [ADDR_W-1:0] from_immed,
    input  logic [ADDR_W-1:0] from_stack,
    input  logic              stall,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [IR_W-1:0]   imem_data,
    output logic [IR_W-1:0]   ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid
);

    localparam int SKID_W = IR_W + ADDR_W;

    logic [ADDR_W-1:0] pc_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;

    pc_sel_t           sel;
    logic              redirect;
    logic              issue;
    logic              accept;
    logic [ADDR_W-1:0] target;

    logic              skid_push;
    logic              skid_pop;
    logic              skid_full;
    logic [SKID_W-1:0] skid_dout;

    assign sel      = pc_sel_t'(pc_mux_sel);
    assign redirect = pc_ld && (sel != SEL_RSVD);
    assign issue    = !stall && !redirect;
    assign accept   = !ir_valid || !stall;

    assign imem_addr = pc_q;
    assign imem_en   = issue && rst_n;

    always_comb begin
        target = INTR_VEC;
        case (sel)
            SEL_IMMED: target = from_immed;
            SEL_STACK: target = from_stack;
            default:   target = INTR_VEC;
        endcase
    end

    // an arriving word parks in the skid when IR is blocked, or when the skid drains into IR
    assign skid_push = inflight_q && !redirect && (!accept || skid_full);
    assign skid_pop  = accept && skid_full && !redirect;

    fetch_skid #(
        .W(SKID_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (skid_push),
        .pop   (skid_pop),
        .clear (redirect),
        .din   ({imem_data, inflight_pc_q}),
        .dout  (skid_dout),
        .full  (skid_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_VEC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q    <= issue;
            inflight_pc_q <= pc_q;
            if (redirect) begin
                pc_q <= target;
            end else if (issue) begin
                pc_q <= pc_q + ADDR_W'(1);
            end
        end
    end

    // IR data is kept on redirect; only the valid flag drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (redirect) begin
            ir_valid <= 1'b0;
        end else if (accept) begin
            if (skid_full) begin
                {ir, ir_pc} <= skid_dout;
                ir_valid    <= 1'b1;
            end else if (inflight_q) begin
                ir       <= imem_data;
                ir_pc    <= inflight_pc_q;
                ir_valid <= 1'b1;
            end else begin
                ir_valid <= 1'b0;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight_q && skid_full && !accept && !redirect));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_ld;
    logic [1:0]  pc_mux_sel;
    logic [9:0]  from_immed;
    logic [9:0]  from_stack;
    logic        stall;
    logic [9:0]  imem_addr;
    logic        imem_en;
    logic [17:0] imem_data = '0;
    logic [17:0] ir;
    logic [9:0]  ir_pc;
    logic        ir_valid;

    int          nchecks = 0;
    int          nerrors = 0;
    logic [9:0]  exp_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (10),
        .IR_W     (18),
        .RESET_VEC(10'h010)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_ld     (pc_ld),
        .pc_mux_sel(pc_mux_sel),
        .from_immed(from_immed),
        .from_stack(from_stack),
        .stall     (stall),
        .imem_addr (imem_addr),
        .imem_en   (imem_en),
        .imem_data (imem_data),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid)
    );

    function automatic logic [17:0] rom_word(input logic [9:0] a);
        return {a ^ 10'h2B7, a[7:0] ^ 8'h5C};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_data <= rom_word(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_ir(input string tag, input logic [9:0] pc);
        check({tag, "_valid"}, 32'(ir_valid), 32'h1);
        check({tag, "_pc"}, 32'(ir_pc), 32'(pc));
        check({tag, "_ir"}, 32'(ir), 32'(rom_word(pc)));
    endtask

    task automatic do_redirect(input string tag, input logic [1:0] s, input logic [9:0] tgt);
        pc_ld      = 1'b1;
        pc_mux_sel = s;
        from_immed = (s == 2'd0) ? tgt : 10'h3C3;
        from_stack = (s == 2'd1) ? tgt : 10'h0F0;
        tick();
        pc_ld = 1'b0;
        check({tag, "_n1_valid"}, 32'(ir_valid), 32'h0);
        check({tag, "_n1_addr"}, 32'(imem_addr), 32'(tgt));
        tick();
        check({tag, "_n2_valid"}, 32'(ir_valid), 32'h0);
        tick();
        expect_ir({tag, "_n3"}, tgt);
        tick();
        expect_ir({tag, "_n4"}, tgt + 10'd1);
        exp_pc = tgt + 10'd2;
    endtask

    initial begin
        rst_n      = 1'b0;
        stall      = 1'b0;
        pc_ld      = 1'b0;
        pc_mux_sel = 2'd0;
        from_immed = '0;
        from_stack = '0;
        tick();
        tick();
        check("rst_valid", 32'(ir_valid), 32'h0);
        check("rst_ir", 32'(ir), 32'h0);
        check("rst_irpc", 32'(ir_pc), 32'h0);
        check("rst_en", 32'(imem_en), 32'h0);
        check("rst_addr", 32'(imem_addr), 32'h010);

        // boot stream from the reset vector
        rst_n = 1'b1;
        #1;
        check("c0_en", 32'(imem_en), 32'h1);
        check("c0_addr", 32'(imem_addr), 32'h010);
        tick();
        check("c1_valid", 32'(ir_valid), 32'h0);
        exp_pc = 10'h010;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_ir("boot", exp_pc);
            exp_pc = exp_pc + 10'd1;
        end

        do_redirect("immed", 2'd0, 10'h2A0);

        // three stall cycles while IR shows 0x005
        do_redirect("to5", 2'd0, 10'h003);
        tick();
        expect_ir("s0", 10'h005);
        stall = 1'b1;
        tick();
        expect_ir("s1", 10'h005);
        check("s1_en", 32'(imem_en), 32'h0);
        tick();
        expect_ir("s2", 10'h005);
        tick();
        stall = 1'b0;
        #1;
        expect_ir("s3", 10'h005);
        check("s3_en", 32'(imem_en), 32'h1);
        tick();
        expect_ir("rel1", 10'h006);
        tick();
        expect_ir("rel2", 10'h007);

        // interrupt redirect while the skid holds a word
        tick();
        expect_ir("i0", 10'h008);
        stall = 1'b1;
        tick();
        expect_ir("i1", 10'h008);
        tick();
        expect_ir("i2", 10'h008);
        pc_ld      = 1'b1;
        pc_mux_sel = 2'd2;
        tick();
        stall = 1'b0;
        pc_ld = 1'b0;
        #1;
        check("intr_m_valid", 32'(ir_valid), 32'h0);
        check("intr_m_addr", 32'(imem_addr), 32'h3FF);
        check("intr_m_en", 32'(imem_en), 32'h1);
        tick();
        check("intr_m1_valid", 32'(ir_valid), 32'h0);
        tick();
        expect_ir("intr_vec", 10'h3FF);
        tick();
        expect_ir("intr_wrap", 10'h000);

        // reserved select leaves the stream alone
        tick();
        expect_ir("rsv0", 10'h001);
        pc_ld      = 1'b1;
        pc_mux_sel = 2'd3;
        from_immed = 10'h2A0;
        #1;
        check("rsv_en", 32'(imem_en), 32'h1);
        tick();
        pc_ld = 1'b0;
        expect_ir("rsv1", 10'h002);
        tick();
        expect_ir("rsv2", 10'h003);
        tick();
        expect_ir("rsv3", 10'h004);

        do_redirect("stack", 2'd1, 10'h123);

        // asynchronous reset mid-cycle
        tick();
        expect_ir("pre_rst", 10'h125);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ir_valid), 32'h0);
        check("arst_en", 32'(imem_en), 32'h0);
        check("arst_addr", 32'(imem_addr), 32'h010);
        tick();
        tick();
        #1;
        rst_n = 1'b1;
        #1;
        check("rel_c0_en", 32'(imem_en), 32'h1);
        check("rel_c0_valid", 32'(ir_valid), 32'h0);
        tick();
        check("rel_c1_valid", 32'(ir_valid), 32'h0);
        tick();
        expect_ir("rel_c2", 10'h010);
        tick();
        expect_ir("rel_c3", 10'h011);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
